// File: rtl/mux_nto1_rr_if.sv
// mux_nto1_rr_if: select controls plus per-channel and output valid/ready handshake for mux_nto1_rr
//   slave  (mux side): en, mode, sel, in_data, in_valid, out_ready in; in_ready, out_data, out_ch, out_valid out
//   master (user side): the mirror of slave
interface mux_nto1_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N_CH);
  logic                    en;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
  modport slave (
    input  en, mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
  modport master (
    output en, mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N_CH x WIDTH registered mux, fixed-select or round-robin grant, valid/ready on every side
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   b     mux_nto1_rr_if.slave: select controls, channel inputs, registered output
module mux_nto1_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  mux_nto1_rr_if.slave  b
);
  localparam int SEL_W = $clog2(N_CH);
  logic [SEL_W-1:0] r_ptr, r_ch, w_rr_g, w_g;
  logic [WIDTH-1:0] r_data, w_data;
  logic             r_valid, w_rr_hit, w_fix_ok, w_gv, w_take;
  // Search starts just after the last granted channel and wraps back to it.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_g   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      logic [SEL_W-1:0] c;
      c = SEL_W'((int'(r_ptr) + k) % N_CH);
      if (!w_rr_hit && b.in_valid[c]) begin
        w_rr_hit = 1'b1;
        w_rr_g   = c;
      end
    end
  end
  // Out-of-range sel simply yields no grant.
  assign w_fix_ok   = (int'(b.sel) < N_CH) ? b.in_valid[b.sel] : 1'b0;
  assign w_gv       = b.mode ? w_rr_hit : w_fix_ok;
  assign w_g        = b.mode ? w_rr_g : b.sel;
  // rst_n gates ready so nothing is offered while reset is held.
  assign w_take     = rst_n & b.en & (!r_valid | b.out_ready) & w_gv;
  assign w_data     = WIDTH'(b.in_data >> (int'(w_g) * WIDTH));
  assign b.in_ready = w_take ? (N_CH'(1) << w_g) : '0;
  assign b.out_data = r_data;
  assign b.out_ch   = r_ch;
  assign b.out_valid = r_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= SEL_W'(N_CH - 1);
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_ch    <= w_g;
      r_ptr   <= w_g;
    end else if (b.out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed and randomized checks of mux_nto1_rr against a behavioural model
module tb_mux_nto1_rr;
  localparam int N = 4, W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_pass = 0;
  bit m_valid;
  int m_data, m_ch, m_ptr;
  int sv_d, sv_c;
  always #5 clk = ~clk;
  mux_nto1_rr_if #(.N_CH(N), .WIDTH(W)) bus();
  mux_nto1_rr #(.N_CH(N), .WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .b(bus.slave));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic mreset();
    m_valid = 0;
    m_data = 0;
    m_ch = 0;
    m_ptr = N - 1;
  endtask
  task automatic drive(input bit en, input bit mode, input int sel, input int v, input bit ordy);
    bus.en = en;
    bus.mode = mode;
    bus.sel = 2'(sel);
    bus.in_valid = 4'(v);
    bus.out_ready = ordy;
    bus.in_data = 32'($urandom);
  endtask
  function automatic bit vbit(input int c);
    return bit'(bus.in_valid >> c);
  endfunction
  // Model: fixed mode grants sel if valid; round-robin takes the first valid channel after ptr.
  task automatic step();
    int g, er, nd;
    bit gv, free;
    g = 0;
    gv = 0;
    free = !m_valid || bus.out_ready;
    if (!bus.mode) begin
      g = int'(bus.sel);
      gv = g < N && vbit(g);
    end else
      for (int k = 1; k <= N; k++)
        if (!gv && vbit((m_ptr + k) % N)) begin
          g = (m_ptr + k) % N;
          gv = 1;
        end
    er = (gv && bus.en && free) ? (1 << g) : 0;
    #1 chk("in_ready", int'(bus.in_ready), er);
    nd = int'(8'(bus.in_data >> (g * W)));
    @(posedge clk);
    if (er != 0) begin
      m_valid = 1;
      m_data = nd;
      m_ch = g;
      m_ptr = g;
    end else if (bus.out_ready) m_valid = 0;
    #1;
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("out_data", int'(bus.out_data), m_data);
    chk("out_ch", int'(bus.out_ch), m_ch);
  endtask
  task automatic pulse_reset();
    @(negedge clk) rst_n = 0;
    mreset();
    @(negedge clk) rst_n = 1;
  endtask
  initial begin
    mreset();
    drive(1, 0, 0, 'hf, 1);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_ready", int'(bus.in_ready), 0);
    @(posedge clk) #1;
    chk("rst_ready_edge", int'(bus.in_ready), 0);
    @(negedge clk) rst_n = 1;
    drive(0, 1, 0, 'hf, 1);
    step();
    chk("en0_ready", int'(bus.in_ready), 0);
    drive(1, 0, 2, 'hf, 1);
    bus.in_data[23:16] = 8'hA5;
    #1 chk("fix_ready", int'(bus.in_ready), 'b0100);
    step();
    chk("fix_data", int'(bus.out_data), 'hA5);
    chk("fix_ch", int'(bus.out_ch), 2);
    chk("fix_valid", int'(bus.out_valid), 1);
    drive(1, 0, 3, 'b0111, 1);
    step();
    chk("fix_nogrant", int'(bus.out_valid), 0);
    pulse_reset();
    drive(1, 1, 0, 'hf, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_all", int'(bus.out_ch), i % N);
    end
    drive(1, 1, 0, 'b1010, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_1010", int'(bus.out_ch), (i % 2) ? 3 : 1);
    end
    drive(1, 1, 0, 'hf, 0);
    sv_d = int'(bus.out_data);
    sv_c = int'(bus.out_ch);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", int'(bus.out_data), sv_d);
      chk("bp_ch", int'(bus.out_ch), sv_c);
      chk("bp_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1;
    step();
    chk("bp_release_valid", int'(bus.out_valid), 1);
    chk("bp_release_ch", int'(bus.out_ch), (sv_c + 1) % N);
    sv_c = int'(bus.out_ch);
    drive(0, 1, 0, 'hf, 1);
    step();
    chk("en_drain", int'(bus.out_valid), 0);
    step();
    chk("en_idle", int'(bus.out_valid), 0);
    drive(1, 1, 0, 'hf, 1);
    step();
    chk("en_resume", int'(bus.out_ch), (sv_c + 1) % N);
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_ready", int'(bus.in_ready), 0);
    mreset();
    @(negedge clk) rst_n = 1;
    step();
    chk("arst_first", int'(bus.out_ch), 0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(7) != 0, 1'($urandom), $urandom_range(3), $urandom_range(15),
            $urandom_range(3) != 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer.
- Replaces single-bit 2:1 enable muxes wherever several producers share one consumer.
- Two select modes: fixed (external `sel`) and round-robin arbitration among valid channels.
- valid/ready handshake on every input channel and on the output; one output register stage.

Parameters:
- N_CH, 4: number of input channels, 2..16.
- WIDTH, 8: data width per channel, >=1.
- SEL_W, $clog2(N_CH): select/channel-index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  1 = accept new data; 0 = block new grants (output still drains)
- mode  input  1  0 = fixed select via `sel`; 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready; combinational, at most one bit high
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=N_CH-1, so the first search starts at channel 0.
  - in_ready=0 while in reset.
- Slot free: free = !out_valid | out_ready.
- Grant, fixed mode (mode=0):
  - g = sel.
  - Grant is valid only if sel < N_CH and in_valid[sel]=1.
  - sel >= N_CH gives no grant and is not an error.
- Grant, round-robin mode (mode=1):
  - g = first channel with in_valid=1, searching ptr+1, ptr+2, … and wrapping modulo N_CH, ending at ptr.
  - If no in_valid bit is set, there is no grant.
- Ready generation:
  - in_ready[g] = en & free & grant_valid.
  - All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid, sel, mode, en and out_ready.
- Transfer: when in_valid[g] & in_ready[g], at the next edge out_data <= in_data[g], out_ch <= g, out_valid <= 1, ptr <= g.
- Pointer updates only on an accepted transfer, in either mode.
- Output drain: out_valid & out_ready with no new transfer in the same cycle → out_valid <= 0; out_data and out_ch hold.
- Simultaneous drain and accept: the register reloads, out_valid stays 1, and throughput is 1 word/cycle.
- Stall: out_valid=1 and out_ready=0 → out_data, out_ch and out_valid hold stable; all in_ready=0.
- Latency: one cycle from input handshake to out_valid.
- en=0: no new grants. A word already registered still drains via out_ready. ptr holds.
- Changes to mode, sel and en take effect on the grant in the same cycle. ptr is retained across mode changes.
- Fairness: with all channels valid in round-robin mode and out_ready=1, grants cycle 0,1,…,N_CH-1,0 with no channel skipped.
- Reset mid-transfer: registered word is discarded and all state returns to reset values immediately.
- Output is never tri-stated; disabled or empty is signalled solely by out_valid=0.

Test Plan:
- Reset and idle: rst_n=0 with in_valid=4'b1111 → out_valid=0, out_data=0, in_ready=0. Release reset with en=0 → in_ready stays 0.
- Fixed mode: mode=0, sel=2, en=1, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1. Then sel=3 with in_valid[3]=0 → no grant; out_valid drops after one drain cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 → out_data and out_ch stable, in_ready=0. Raise out_ready → one drain plus one accept in the same cycle; out_valid stays 1.
- en gating mid-stream: en drops while out_valid=1 → registered word drains on out_ready, no further accepts, ptr unchanged. Raise en → round-robin resumes at ptr+1.
- Async reset mid-stream: assert rst_n=0 between clock edges during continuous round-robin traffic → out_valid=0 immediately. After release, the first grant goes to channel 0.
